fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: loads a program into an external synchronous memory,
// then fetches words one at a time with a valid/ready handoff to decode.
module fetch_unit #(
  parameter int unsigned INSTRUCTION_WIDTH = 20,
  parameter int unsigned MEMORY_SIZE       = 32,
  parameter logic [3:0]  HALT_OPCODE       = 4'hF,
  localparam int unsigned AW               = $clog2(MEMORY_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  input  logic                         load_last,
  input  logic                         run_start,
  input  logic                         redirect_valid,
  input  logic [AW-1:0]                redirect_addr,
  input  logic                         instr_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
  output logic [AW-1:0]                mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  output logic                         mem_write_en,
  output logic                         instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [AW-1:0]                instr_pc,
  output logic                         halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RESP,
    S_HOLD,
    S_HALT
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEMORY_SIZE - 1);

  state_t                         state_q, state_d;
  logic [AW-1:0]                  pc_q, pc_d;
  logic [AW-1:0]                  load_cnt_q, load_cnt_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic [AW-1:0]                  instr_pc_q, instr_pc_d;
  logic                           instr_valid_q, instr_valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      load_cnt_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      load_cnt_q    <= load_cnt_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_cnt_d    = load_cnt_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
        end else if (run_start) begin
          state_d = S_REQ;
          pc_d    = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          load_cnt_d = (load_cnt_q == LAST_ADDR) ? '0 : load_cnt_q + 1'b1;
          if (load_last || load_cnt_q == LAST_ADDR) state_d = S_IDLE;
        end
      end
      S_REQ: state_d = S_RESP;
      S_RESP: begin
        instr_d       = mem_rdata;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
        pc_d          = (pc_q == LAST_ADDR) ? '0 : pc_q + 1'b1;
        state_d       = S_HOLD;
      end
      S_HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d = (instr_q[INSTRUCTION_WIDTH-1 -: 4] == HALT_OPCODE) ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        if (run_start) begin
          state_d = S_REQ;
          pc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect discards any in-flight capture or handshake in the same cycle.
    if (redirect_valid && (state_q == S_REQ || state_q == S_RESP || state_q == S_HOLD)) begin
      state_d       = S_REQ;
      pc_d          = redirect_addr;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
    end
  end

  assign mem_addr     = (state_q == S_LOAD) ? load_cnt_q : pc_q;
  assign mem_wdata    = load_data;
  assign mem_write_en = (state_q == S_LOAD) && load_valid;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign halted       = (state_q == S_HALT);

endmodule
